uart_tx_ticked: RTL and testbench

- Serial transmitter driven by the baud-tick pulse from the existing enabled-prescaler counter.
- Accepts one byte per valid/ready handshake and shifts it out LSB-first as an 8N1-style frame on tx.
- Bit boundaries occur only on tick pulses.
- Sits between the processor's output ('.') path and the board pin; the prescaler instance lives in the parent.

---
 rtl/uart_pkg.sv | 33 +++
 rtl/uart_tx_ticked_if.sv | 11 +
 rtl/uart_tx_ticked.sv | 133 +++++++++++++
 tb/tb_uart_tx_ticked.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the tick-driven UART transmitter.
// Optional parity support is selected with the UART_TX_PARITY_EN macro.
package uart_pkg;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SYNC   = 3'd1,
    START  = 3'd2,
    DATA   = 3'd3,
    PARITY = 3'd4,
    STOP   = 3'd5
  } state_t;
  localparam bit PARITY_ON = 1'b1;
`else
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SYNC   = 3'd1,
    START  = 3'd2,
    DATA   = 3'd3,
    STOP   = 3'd5
  } state_t;
  localparam bit PARITY_ON = 1'b0;
`endif

  localparam logic LINE_IDLE = 1'b1;

  // Number of tick periods from the first tick after accept until ready returns.
  function automatic int frame_len(input int data_bits, input int stop_bits, input bit parity);
    return 1 + data_bits + (parity ? 1 : 0) + stop_bits;
  endfunction

endpackage

// File: rtl/uart_tx_ticked_if.sv
// Byte handshake between the producer and the UART transmitter.
interface uart_tx_ticked_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] data_in;
  logic                 valid;
  logic                 ready;

  modport master (output data_in, output valid, input ready);
  modport slave  (input data_in, input valid, output ready);
endinterface

// File: rtl/uart_tx_ticked.sv
// UART transmitter whose bit boundaries fall only on externally supplied baud ticks.
// Define UART_TX_PARITY_EN to append an even-parity bit after the data bits.
module uart_tx_ticked
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick,
  uart_tx_ticked_if.slave    s,
  output logic               busy,
  output logic               tx
);

  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam int SW = (STOP_BITS > 1) ? $clog2(STOP_BITS) : 1;

  state_t                state_q, state_d;
  logic [DATA_BITS-1:0]  shift_q, shift_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [SW-1:0]         stop_q, stop_d;
  logic                  tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
  logic                  par_q, par_d;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      stop_q  <= '0;
      tx_q    <= LINE_IDLE;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
      tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    stop_d  = stop_q;
    tx_d    = tx_q;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      // A tick on the accept edge is deliberately not consumed: SYNC waits for
      // the next one so the start bit lasts a full period.
      IDLE: begin
        tx_d = LINE_IDLE;
        if (s.valid) begin
          shift_d = s.data_in;
`ifdef UART_TX_PARITY_EN
          par_d   = ^s.data_in;
`endif
          state_d = SYNC;
        end
      end
      SYNC: begin
        if (tick) begin
          state_d = START;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (tick) begin
          state_d = DATA;
          tx_d    = shift_q[0];
          bit_d   = '0;
        end
      end
      DATA: begin
        if (tick) begin
          if (bit_q == BW'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
            tx_d    = par_q;
`else
            state_d = STOP;
            tx_d    = LINE_IDLE;
            stop_d  = '0;
`endif
          end else begin
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
            bit_d   = bit_q + BW'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (tick) begin
          state_d = STOP;
          tx_d    = LINE_IDLE;
          stop_d  = '0;
        end
      end
`endif
      STOP: begin
        if (tick) begin
          if (stop_q == SW'(STOP_BITS - 1)) begin
            state_d = IDLE;
          end else begin
            stop_d = stop_q + SW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = LINE_IDLE;
      end
    endcase
  end

  assign s.ready = (state_q == IDLE);
  assign busy    = (state_q != IDLE);
  assign tx      = tx_q;

endmodule

// File: tb/tb_uart_tx_ticked.sv
// Directed bench for uart_tx_ticked: expected line bits are queued at accept and
// popped on every tick edge; three instances cover 8N1, 5-bit tick-high and two stop bits.
`timescale 1ns/1ps
module tb_uart_tx_ticked;

`ifdef UART_TX_PARITY_EN
  localparam bit PAR_ON = 1'b1;
`else
  localparam bit PAR_ON = 1'b0;
`endif

  logic clk;
  logic reset;
  logic tick;
  logic tick_hi;
  logic busy0, busy1, busy2;
  logic tx0, tx1, tx2;

  uart_tx_ticked_if #(.DATA_BITS(8)) u0 ();
  uart_tx_ticked_if #(.DATA_BITS(5)) u1 ();
  uart_tx_ticked_if #(.DATA_BITS(8)) u2 ();

  uart_tx_ticked #(.DATA_BITS(8), .STOP_BITS(1)) dut0 (
    .clk(clk), .reset(reset), .tick(tick), .s(u0.slave), .busy(busy0), .tx(tx0));
  uart_tx_ticked #(.DATA_BITS(5), .STOP_BITS(1)) dut1 (
    .clk(clk), .reset(reset), .tick(tick_hi), .s(u1.slave), .busy(busy1), .tx(tx1));
  uart_tx_ticked #(.DATA_BITS(8), .STOP_BITS(2)) dut2 (
    .clk(clk), .reset(reset), .tick(tick), .s(u2.slave), .busy(busy2), .tx(tx2));

  int   checks = 0;
  int   errors = 0;
  int   ph = 1;
  logic last_tick = 1'b0;
  logic q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs == exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic get_tx(input int sel);
    case (sel)
      0: return tx0;
      1: return tx1;
      default: return tx2;
    endcase
  endfunction

  function automatic logic get_ready(input int sel);
    case (sel)
      0: return u0.ready;
      1: return u1.ready;
      default: return u2.ready;
    endcase
  endfunction

  function automatic logic get_busy(input int sel);
    case (sel)
      0: return busy0;
      1: return busy1;
      default: return busy2;
    endcase
  endfunction

  task automatic set_in(input int sel, input logic v, input logic [7:0] d);
    case (sel)
      0: begin u0.valid = v; u0.data_in = d; end
      1: begin u1.valid = v; u1.data_in = d[4:0]; end
      default: begin u2.valid = v; u2.data_in = d; end
    endcase
  endtask

  // Tick pulses every 4th cycle; inputs change 1ns after each rising edge.
  task automatic step();
    tick = (ph == 0);
    @(posedge clk);
    #1;
    last_tick = tick;
    ph = (ph + 1) % 4;
  endtask

  task automatic load(input logic [7:0] d, input int nbits, input int nstop);
    logic p;
    p = 1'b0;
    q.push_back(1'b0);
    for (int i = 0; i < nbits; i++) begin
      q.push_back(d[i]);
      p = p ^ d[i];
    end
    if (PAR_ON) q.push_back(p);
    for (int i = 0; i < nstop; i++) q.push_back(1'b1);
  endtask

  task automatic accept(input int sel, input logic [7:0] d, input int nbits, input int nstop,
                        input logic nv, input logic [7:0] nd);
    set_in(sel, 1'b1, d);
    step();
    chk("accept_ready_low", get_ready(sel), 1'b0);
    chk("accept_busy_high", get_busy(sel), 1'b1);
    chk("accept_tx_idle", get_tx(sel), 1'b1);
    set_in(sel, nv, nd);
    load(d, nbits, nstop);
  endtask

  // Follows one frame: the line must hold each queued bit until the next tick.
  task automatic watch(input int sel, input int exp_periods, input int abort_ticks);
    logic e;
    int   ticks;
    int   n;
    e = 1'b1;
    ticks = 0;
    n = 0;
    forever begin
      step();
      n++;
      if (sel == 1 || last_tick) begin
        ticks++;
        if (q.size() == 0) begin
          chk("end_ready", get_ready(sel), 1'b1);
          chk("end_busy", get_busy(sel), 1'b0);
          chk("end_tx", get_tx(sel), 1'b1);
          chk_int("frame_periods", ticks - 1, exp_periods);
          return;
        end
        e = q.pop_front();
      end
      chk("tx_bit", get_tx(sel), e);
      chk("busy_in_frame", get_busy(sel), 1'b1);
      chk("ready_in_frame", get_ready(sel), 1'b0);
      if (abort_ticks != 0 && ticks == abort_ticks) return;
      if (n > 200) begin
        checks++;
        errors++;
        $error("FAIL frame_timeout observed=%0d cycles expected<=200", n);
        return;
      end
    end
  endtask

  initial begin
    tick_hi = 1'b1;
    tick = 1'b0;
    reset = 1'b1;
    set_in(0, 1'b0, 8'h00);
    set_in(1, 1'b0, 8'h00);
    set_in(2, 1'b0, 8'h00);
    #1 reset = 1'b0;
    #2;
    for (int s = 0; s < 3; s++) begin
      chk("rst_tx", get_tx(s), 1'b1);
      chk("rst_ready", get_ready(s), 1'b1);
      chk("rst_busy", get_busy(s), 1'b0);
    end
    @(posedge clk);
    #3 reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("idle_tx", tx0, 1'b1);
      chk("idle_ready", u0.ready, 1'b1);
    end

    accept(0, 8'h55, 8, 1, 1'b0, 8'hAA);
    watch(0, 10 + (PAR_ON ? 1 : 0), 0);

    accept(0, 8'h07, 8, 1, 1'b0, 8'hF8);
    watch(0, 10 + (PAR_ON ? 1 : 0), 0);

    accept(2, 8'h07, 8, 2, 1'b0, 8'h00);
    watch(2, 11 + (PAR_ON ? 1 : 0), 0);

    // valid stays high across both frames; the second byte is presented while busy
    accept(0, 8'hA3, 8, 1, 1'b1, 8'h3C);
    watch(0, 10 + (PAR_ON ? 1 : 0), 0);
    accept(0, 8'h3C, 8, 1, 1'b0, 8'hFF);
    watch(0, 10 + (PAR_ON ? 1 : 0), 0);

    while (ph != 0) step();
    accept(0, 8'hC9, 8, 1, 1'b0, 8'h00);
    watch(0, 10 + (PAR_ON ? 1 : 0), 0);

    // abort during data bit 3 (0x96 bit 3 is 0, so the line visibly returns high)
    accept(0, 8'h96, 8, 1, 1'b0, 8'h00);
    watch(0, 0, 5);
    step();
    chk("pre_abort_tx", tx0, 1'b0);
    #2 reset = 1'b0;
    #1;
    chk("abort_tx", tx0, 1'b1);
    chk("abort_ready", u0.ready, 1'b1);
    chk("abort_busy", busy0, 1'b0);
    #2 reset = 1'b1;
    q.delete();
    step();
    accept(0, 8'hF0, 8, 1, 1'b0, 8'h0F);
    watch(0, 10 + (PAR_ON ? 1 : 0), 0);

    accept(1, 8'h1F, 5, 1, 1'b0, 8'h00);
    watch(1, 7 + (PAR_ON ? 1 : 0), 0);
    accept(1, 8'h12, 5, 1, 1'b0, 8'h0D);
    watch(1, 7 + (PAR_ON ? 1 : 0), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
